ipm2l_apm_distributed_fifo: RTL
===============================

Name: ipm2l_apm_distributed_fifo

Overview:
Single-clock synchronous FIFO built on distributed (LUT) RAM, used to buffer and decouple APM multiplier operand/result streams in the data pipeline. It is parametrised in width and depth and supports standard or first-word-fall-through (FWFT) read mode. It provides an optional output register, programmable almost-full/almost-empty thresholds, a fill count, and sticky-free overflow/underflow error pulses.

Parameters:
ADDR_WIDTH, 4, log2 depth; range 4-10; DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 16, word width; range 1-256
FWFT, 0, 0 = standard read (data after rd_en); 1 = head word presented while !empty
OUT_REG, 0, standard mode only: 1 adds an output register (+1 read latency); ignored when FWFT=1
ALMOST_FULL_NUM, 2**ADDR_WIDTH-2, almost_full asserted when count >= value; range 1..DEPTH
ALMOST_EMPTY_NUM, 2, almost_empty asserted when count <= value; range 0..DEPTH-1

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
wr_data  input  DATA_WIDTH  write word
wr_en  input  1  write request
rd_en  input  1  read request
rd_data  output  DATA_WIDTH  read word
full  output  1  count == DEPTH
almost_full  output  1  count >= ALMOST_FULL_NUM
empty  output  1  count == 0
almost_empty  output  1  count <= ALMOST_EMPTY_NUM
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected previous cycle
underflow  output  1  one-cycle pulse: read rejected previous cycle

Behaviour:
- Reset (async assert, synchronous release): wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=underflow=0, registered rd_data=0. Memory contents are not reset; initial contents are zero.
- Write is accepted iff wr_en && !full. The word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
- Read is accepted iff rd_en && !empty. rd_ptr increments modulo DEPTH.
- Flags and count are registered and reflect state after the current edge; there is no combinational path from wr_en/rd_en to any flag.
- Simultaneous accepted read+write: count unchanged, both pointers advance.
- When full, a write is rejected even if a read is accepted in the same cycle; the read completes and count becomes DEPTH-1.
- When empty, a read is rejected even if a write is accepted in the same cycle; count becomes 1.
- Rejected write → overflow=1 on the next cycle for one cycle. Rejected read → underflow=1 likewise. State is unaffected by either.
- Standard mode, OUT_REG=0: rd_data is registered from mem[rd_ptr] on an accepted read, so data is valid 1 cycle after the rd_en edge. It holds its value otherwise.
- Standard mode, OUT_REG=1: a second register stage, giving 2-cycle latency. The stage-2 register loads every cycle.
- FWFT mode: rd_data = mem[rd_ptr] (asynchronous distributed read). It is valid whenever empty=0 and is don't-care when empty=1. An accepted rd_en pops the shown word, and the next word appears after the edge. Write-to-empty-deassert latency is 1 cycle.
- Pointer wrap: DEPTH writes then DEPTH reads return to ptr=0 with no data loss. Count uses ADDR_WIDTH+1 bits so it distinguishes full from empty.
- Reset mid-operation: all control state is cleared immediately; data in flight is discarded, and the output register clears to 0.

Decomposition:
- Package ipm2l_apm_fifo_pkg holds the FWFT/standard mode constants, the count-width helper (ADDR_WIDTH+1), and the threshold-legality checks (elaboration error when out of range).
- Storage sub-module: the existing ipm2l_apm_distributed_sdpram, instantiated with wr_clk=rd_clk=clk, OUT_REG=0, and its rst tied to !rst_n.
- Pointers, count, flags, error pulses and the output registers live in the top-level module.

Test Plan:
1. ADDR_WIDTH=4, DATA_WIDTH=8, standard mode, OUT_REG=0: write 0x01..0x10 → full=1 and count=16 after the 16th write. Then 16 reads → rd_data sequence 0x01..0x10 with 1-cycle latency, and empty=1 after the last read.
2. Full FIFO, one extra write of 0xAA → overflow pulse for exactly 1 cycle, count stays 16, and 0xAA is never read. Empty FIFO, rd_en → underflow pulse, rd_data unchanged.
3. Count=8, wr_en=rd_en=1 for 20 cycles, data 0x20..0x33 → count stays 8, pointers wrap, and reads return in order. Full state with simultaneous rd_en+wr_en → count=15, write dropped, overflow=1.
4. FWFT=1: write 0x5A into empty FIFO → empty=0 and rd_data=0x5A on the next cycle without rd_en. rd_en → empty=1.
5. ALMOST_FULL_NUM=12, ALMOST_EMPTY_NUM=3: fill one word at a time → almost_empty deasserts at count=4, almost_full asserts at count=12. Drain → almost_full deasserts at count=11.
6. OUT_REG=1, rst_n pulsed low while count=5 → all flags and count return to reset values asynchronously, rd_data=0. A subsequent write/read of 0x77 returns 0x77 with 2-cycle latency.

Source files
------------

// File: rtl/ipm2l_apm_fifo_pkg.sv
// ipm2l_apm_fifo_pkg
// Shared definitions for the APM distributed-RAM FIFO:
//   - read-mode selection (standard, standard + output register, FWFT)
//   - occupancy counter width helper (one extra bit so full and empty differ)
//   - parameter legality checks used at elaboration time by the FIFO top
package ipm2l_apm_fifo_pkg;

   // Values accepted by the FIFO's FWFT parameter.
   localparam int unsigned FwftOff = 0;
   localparam int unsigned FwftOn  = 1;

   typedef enum logic [1:0] {
      RdModeStd,
      RdModeStdReg,
      RdModeFwft
   } rd_mode_e;

   // FWFT takes priority: the output register only exists in standard mode.
   function automatic rd_mode_e rd_mode_sel(int unsigned fwft, int unsigned out_reg);
      if (fwft == FwftOn) return RdModeFwft;
      if (out_reg != 0) return RdModeStdReg;
      return RdModeStd;
   endfunction

   function automatic int unsigned cnt_width(int unsigned addr_width);
      return addr_width + 1;
   endfunction

   function automatic bit addr_width_legal(int unsigned addr_width);
      return (addr_width >= 4) && (addr_width <= 10);
   endfunction

   function automatic bit data_width_legal(int unsigned data_width);
      return (data_width >= 1) && (data_width <= 256);
   endfunction

   function automatic bit fwft_legal(int unsigned fwft);
      return (fwft == FwftOff) || (fwft == FwftOn);
   endfunction

   function automatic bit almost_full_legal(int unsigned af_num, int unsigned addr_width);
      return (af_num >= 1) && (af_num <= (32'd1 << addr_width));
   endfunction

   function automatic bit almost_empty_legal(int unsigned ae_num, int unsigned addr_width);
      return ae_num <= ((32'd1 << addr_width) - 1);
   endfunction

endpackage

// File: rtl/ipm2l_apm_distributed_sdpram.sv
// ipm2l_apm_distributed_sdpram
// Simple dual-port distributed (LUT) RAM: one synchronous write port and one
// asynchronous read port, with an optional registered read output.
// Ports:
//   wr_clk, wr_en, wr_addr, wr_data : synchronous write port
//   rd_clk, rst                     : read-register clock and active-high async reset
//   rd_addr, rd_data                : read port (combinational when OUT_REG=0)
// Memory contents are not reset.
module ipm2l_apm_distributed_sdpram #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned OUT_REG    = 0
) (
   input  logic                  wr_clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [Depth];
   logic [DATA_WIDTH-1:0] rd_raw;

   always_ff @(posedge wr_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_raw = mem[rd_addr];

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rd_data_q;

      always_ff @(posedge rd_clk or posedge rst) begin
         if (rst) begin
            rd_data_q <= '0;
         end else begin
            rd_data_q <= rd_raw;
         end
      end

      assign rd_data = rd_data_q;
   end else begin : g_no_out_reg
      // Read clock and reset only feed the output register.
      logic unused_rd_ctrl;
      assign unused_rd_ctrl = rd_clk ^ rst;
      assign rd_data = rd_raw;
   end

endmodule

// File: rtl/ipm2l_apm_distributed_fifo.sv
// ipm2l_apm_distributed_fifo
// Single-clock FIFO on distributed RAM for APM operand/result streams.
// Read modes: standard (1-cycle latency), standard with output register
// (2-cycle latency), or first-word-fall-through (head word shown while !empty).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   wr_data, wr_en       : write side; write accepted when wr_en && !full
//   rd_en, rd_data       : read side; read accepted when rd_en && !empty
//   full, almost_full    : count == DEPTH, count >= ALMOST_FULL_NUM
//   empty, almost_empty  : count == 0, count <= ALMOST_EMPTY_NUM
//   count                : occupancy 0..DEPTH
//   overflow, underflow  : one-cycle pulse after a rejected write / read
// All flags and count are registered and describe the state after the edge.
module ipm2l_apm_distributed_fifo
   import ipm2l_apm_fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH       = 4,
   parameter int unsigned DATA_WIDTH       = 16,
   parameter int unsigned FWFT             = 0,
   parameter int unsigned OUT_REG          = 0,
   parameter int unsigned ALMOST_FULL_NUM  = 2 ** ADDR_WIDTH - 2,
   parameter int unsigned ALMOST_EMPTY_NUM = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  almost_full,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
   localparam int unsigned CntW   = cnt_width(ADDR_WIDTH);
   localparam rd_mode_e    RdMode = rd_mode_sel(FWFT, OUT_REG);

   localparam logic [CntW-1:0]       DepthCnt = CntW'(Depth);
   localparam logic [CntW-1:0]       AfCnt    = CntW'(ALMOST_FULL_NUM);
   localparam logic [CntW-1:0]       AeCnt    = CntW'(ALMOST_EMPTY_NUM);
   localparam logic [CntW-1:0]       CntOne   = CntW'(1);
   localparam logic [ADDR_WIDTH-1:0] PtrOne   = ADDR_WIDTH'(1);

   // Elaboration-time parameter checks.
   if (!addr_width_legal(ADDR_WIDTH)) begin : g_bad_addr_width
      $error("ADDR_WIDTH must be in 4..10");
   end
   if (!data_width_legal(DATA_WIDTH)) begin : g_bad_data_width
      $error("DATA_WIDTH must be in 1..256");
   end
   if (!fwft_legal(FWFT)) begin : g_bad_fwft
      $error("FWFT must be 0 or 1");
   end
   if (!almost_full_legal(ALMOST_FULL_NUM, ADDR_WIDTH)) begin : g_bad_af
      $error("ALMOST_FULL_NUM must be in 1..DEPTH");
   end
   if (!almost_empty_legal(ALMOST_EMPTY_NUM, ADDR_WIDTH)) begin : g_bad_ae
      $error("ALMOST_EMPTY_NUM must be in 0..DEPTH-1");
   end

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic                  full_q, full_d;
   logic                  almost_full_q, almost_full_d;
   logic                  empty_q, empty_d;
   logic                  almost_empty_q, almost_empty_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ram_rst;
   logic [DATA_WIDTH-1:0] mem_rd;

   // Acceptance uses only registered flags: a full FIFO rejects a write even
   // when a read frees a slot on the same edge, and likewise for empty.
   always_comb begin
      wr_acc = wr_en & ~full_q;
      rd_acc = rd_en & ~empty_q;

      wr_ptr_d = wr_acc ? wr_ptr_q + PtrOne : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + PtrOne : rd_ptr_q;

      count_d = count_q;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase

      full_d         = (count_d == DepthCnt);
      empty_d        = (count_d == '0);
      almost_full_d  = (count_d >= AfCnt);
      almost_empty_d = (count_d <= AeCnt);

      overflow_d  = wr_en & full_q;
      underflow_d = rd_en & empty_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         almost_full_q  <= 1'b0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         full_q         <= full_d;
         almost_full_q  <= almost_full_d;
         empty_q        <= empty_d;
         almost_empty_q <= almost_empty_d;
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
      end
   end

   assign ram_rst = ~rst_n;

   ipm2l_apm_distributed_sdpram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_REG    (0)
   ) u_ram (
      .wr_clk  (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data),
      .rd_clk  (clk),
      .rst     (ram_rst),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rd)
   );

   if (RdMode == RdModeFwft) begin : g_fwft
      // Head word is driven straight from the RAM; meaningless while empty.
      assign rd_data = mem_rd;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;

      // Stage 1 captures the head word only on an accepted read.
      always_comb begin
         rd_data1_d = rd_acc ? mem_rd : rd_data1_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_data1_q <= '0;
         end else begin
            rd_data1_q <= rd_data1_d;
         end
      end

      if (RdMode == RdModeStdReg) begin : g_out_reg
         logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;

         always_comb begin
            rd_data2_d = rd_data1_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_data2_q <= '0;
            end else begin
               rd_data2_q <= rd_data2_d;
            end
         end

         assign rd_data = rd_data2_q;
      end else begin : g_no_out_reg
         assign rd_data = rd_data1_q;
      end
   end

   assign full         = full_q;
   assign almost_full  = almost_full_q;
   assign empty        = empty_q;
   assign almost_empty = almost_empty_q;
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule
